// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared state encoding, phase constants and line-drive helper for the I2C sequencer
package i2c_seq_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, WR, RD, DACK, STOP} state_t;
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;
  localparam int BITS_PER_BYTE = 8;
  // {scl_oe, sda_oe} for a state, quarter phase and the outgoing bit b
  function automatic logic [1:0] line_oe(input state_t s, input logic [1:0] ph, input logic b);
    line_oe = s == IDLE  ? 2'b00 :
              s == START ? {1'b0, ph >= PH_2} :
              s == STOP  ? {ph <= PH_1, ph != PH_3} :
                           {ph <= PH_1, (s == ADDR || s == WR) & ~b};
  endfunction
endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: quarter-bit phase generator with SCL-stretch hold in phase 2
module i2c_phase_timer
  import i2c_seq_pkg::*;
#(
  parameter int DIVIDER = 6500,
  parameter int CBITS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       hold,
  output logic [1:0] phase,
  output logic       phase_last
);
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [1:0] phase_q, phase_d;
  logic stall;
  // next count/phase; the counter freezes while the slave stretches SCL in phase 2
  always_comb begin
    stall = hold && phase_q == PH_2;
    phase_last = run && !stall && cnt_q == CBITS'(DIVIDER - 1);
    cnt_d = !run ? '0 : stall ? cnt_q : phase_last ? '0 : cnt_q + 1'b1;
    phase_d = !run ? PH_0 : phase_q + {1'b0, phase_last};
  end
  // timer state
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      phase_q <= PH_0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  assign phase = phase_q;
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: single-master I2C byte transaction controller; define I2C_SEQ_ARB_LOSS_EN for arbitration-loss detection
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DIVIDER = 6500,
  parameter int CBITS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata
`ifdef I2C_SEQ_ARB_LOSS_EN
  ,
  output logic       arb_lost
`endif
);
  state_t state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic rw_q, rw_d, ack_q, ack_d, nack_q, nack_d, done_q, done_d;
  logic busy_q, scl_oe_q, sda_oe_q;
  logic [1:0] phase, ph_n, oe_d;
  logic phase_last, sample, bit_end;
`ifdef I2C_SEQ_ARB_LOSS_EN
  logic arb_q, arb_d;
`endif

  i2c_phase_timer #(.DIVIDER(DIVIDER), .CBITS(CBITS)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(state_q != IDLE),
    .hold(~scl_in),
    .phase(phase),
    .phase_last(phase_last)
  );

  // transaction sequencing; line enables are computed from the next state and phase so they change with it
  always_comb begin
    sample = phase == PH_2 && phase_last;
    bit_end = phase == PH_3 && phase_last;
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d = rw_q;
    ack_d = ack_q;
    nack_d = nack_q;
    done_d = 1'b0;
`ifdef I2C_SEQ_ARB_LOSS_EN
    arb_d = arb_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        state_d = START;
        shift_d = {addr, rw};
        wdata_d = wdata;
        rw_d = rw;
        bit_d = '0;
        nack_d = 1'b0;
`ifdef I2C_SEQ_ARB_LOSS_EN
        arb_d = 1'b0;
`endif
      end
      START: if (bit_end) state_d = ADDR;
      ADDR, WR, RD: begin
        if (sample && state_q == RD) rdata_d = {rdata_q[6:0], sda_in};
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(BITS_PER_BYTE - 1)) state_d = state_q == ADDR ? AACK : DACK;
        end
`ifdef I2C_SEQ_ARB_LOSS_EN
        if (sample && state_q != RD && !sda_oe_q && !sda_in) begin
          state_d = IDLE;
          done_d = 1'b1;
          arb_d = 1'b1;
        end
`endif
      end
      AACK: begin
        if (sample) ack_d = sda_in;
        if (bit_end) begin
          state_d = ack_q ? STOP : rw_q ? RD : WR;
          nack_d = ack_q;
          shift_d = wdata_q;
        end
      end
      DACK: begin
        if (sample && !rw_q && sda_in) nack_d = 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ph_n = (state_q == IDLE || state_d == IDLE) ? PH_0 : phase + {1'b0, phase_last};
    oe_d = line_oe(state_d, ph_n, shift_d[7]);
  end

  // state and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      shift_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q <= 1'b0;
      ack_q <= 1'b0;
      nack_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
`ifdef I2C_SEQ_ARB_LOSS_EN
      arb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q <= rw_d;
      ack_q <= ack_d;
      nack_q <= nack_d;
      done_q <= done_d;
      busy_q <= state_d != IDLE;
      {scl_oe_q, sda_oe_q} <= oe_d;
`ifdef I2C_SEQ_ARB_LOSS_EN
      arb_q <= arb_d;
`endif
    end

  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;
  assign busy = busy_q;
  assign done = done_q;
  assign nack = nack_q;
  assign rdata = rdata_q;
`ifdef I2C_SEQ_ARB_LOSS_EN
  assign arb_lost = arb_q;
`endif
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: vector-driven bench with an open-drain I2C slave model and byte scoreboard
module tb_i2c_txn_sequencer;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic scl_in, sda_in, scl_oe, sda_oe, busy, done, nack;
  logic [7:0] rdata;
  logic stretch = 1'b0, slave_pull = 1'b0;

  assign scl_in = !scl_oe && !stretch;
  assign sda_in = !sda_oe && !slave_pull;
  always #5 clk = ~clk;

  i2c_txn_sequencer #(.DIVIDER(2), .CBITS(15)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .busy(busy), .done(done), .nack(nack), .rdata(rdata)
  );

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       aack;
    logic       dack;
    logic [7:0] rd;
    logic       st;
    logic       exp_nack;
    int         exp_lat;
  } vec_t;

  vec_t cur;
  vec_t vecs[7];
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdata;

  int bitn = 0, byten = 0, scnt = 0, stops = 0, rx_n = 0;
  logic [7:0] rx = '0;
  logic [7:0] rx_b[4];
  logic dack_lvl = 1'b0, sused = 1'b0, scl_p = 1'b1, sda_p = 1'b1, scl_l, sda_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave model: decodes START/STOP, collects master bytes, drives ACKs, read data and one SCL stretch
  always @(negedge clk) begin
    if (scnt != 0) begin
      scnt--;
      if (scnt == 0) stretch = 1'b0;
    end else if (cur.st && !sused && byten == 0 && bitn == 3 && !scl_oe && !scl_p) begin
      stretch = 1'b1;
      scnt = 10;
      sused = 1'b1;
    end
    scl_l = !scl_oe && !stretch;
    sda_l = !sda_oe && !slave_pull;
    if (rst) begin
      bitn = 0;
      byten = 0;
      rx_n = 0;
      slave_pull = 1'b0;
    end else if (scl_p && scl_l && sda_p && !sda_l) begin
      bitn = 0;
      byten = 0;
      rx_n = 0;
      sused = 1'b0;
    end else if (scl_p && scl_l && !sda_p && sda_l) begin
      stops++;
    end else if (!scl_p && scl_l) begin
      if (bitn < 8) rx = {rx[6:0], sda_l};
      else if (byten == 1) dack_lvl = sda_l;
      bitn++;
      if (bitn == 8 && (byten == 0 || !cur.rw) && rx_n < 4) begin
        rx_b[rx_n] = rx;
        rx_n++;
      end
    end else if (scl_p && !scl_l) begin
      if (bitn == 8) slave_pull = byten == 0 ? !cur.aack : (!cur.rw && !cur.dack);
      else if (bitn == 9) begin
        bitn = 0;
        byten++;
        slave_pull = byten == 1 && cur.rw && !cur.rd[7];
      end else if (byten == 1 && cur.rw && bitn < 8) slave_pull = !cur.rd[7 - bitn];
    end
    scl_p = scl_l;
    sda_p = sda_l;
  end

  task automatic issue(input vec_t v, output int lat);
    int n;
    @(negedge clk);
    req = 1'b1;
    rw = v.rw;
    addr = v.addr;
    wdata = v.wdata;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(busy), 1);
    req = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 1);
    lat = n;
  endtask

  task automatic check_bytes();
    chk("byte_count", 32'(rx_n), 32'(exp_q.size()));
    for (int k = 0; k < 4 && exp_q.size() > 0; k++)
      chk("byte", k < rx_n ? 32'(rx_b[k]) : 32'hFFFF_FFFF, 32'(exp_q.pop_front()));
  endtask

  initial begin
    int lat, s0, n, dn;
    vecs[0] = '{1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 160};
    vecs[1] = '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 88};
    vecs[2] = '{1'b1, 7'h3C, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 160};
    vecs[3] = '{1'b0, 7'h12, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 160};
    vecs[4] = '{1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 170};
    vecs[5] = '{1'b1, 7'h7F, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 160};
    vecs[6] = '{1'b1, 7'h2A, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 88};
    cur = vecs[0];
    exp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", 32'(scl_oe), 0);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_nack", 32'(nack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      cur = vecs[i];
      s0 = stops;
      exp_q.push_back({cur.addr, cur.rw});
      if (!cur.rw && !cur.aack) exp_q.push_back(cur.wdata);
      if (cur.rw && !cur.aack) exp_rdata = cur.rd;
      issue(cur, lat);
      chk("latency", 32'(lat), 32'(cur.exp_lat));
      chk("nack", 32'(nack), 32'(cur.exp_nack));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("busy_at_done", 32'(busy), 0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
      chk("stop_seen", 32'(stops - s0), 1);
      check_bytes();
      if (cur.rw && !cur.aack) chk("dack_release", 32'(dack_lvl), 1);
      repeat (4) @(negedge clk);
    end
    // reset in the middle of the write data byte
    cur = vecs[0];
    s0 = stops;
    @(negedge clk);
    req = 1'b1;
    rw = 1'b0;
    addr = 7'h50;
    wdata = 8'hA5;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!(byten == 1 && bitn == 4) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_bit4", 32'(n < 500), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_scl_oe", 32'(scl_oe), 0);
    chk("mid_rst_sda_oe", 32'(sda_oe), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 8'h00;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_rst", 32'(dn), 0);
    chk("no_stop_after_rst", 32'(stops - s0), 0);
    chk("rdata_cleared", 32'(rdata), 0);
    exp_q.push_back({7'h50, 1'b0});
    exp_q.push_back(8'hA5);
    issue(vecs[0], lat);
    chk("post_rst_latency", 32'(lat), 160);
    chk("post_rst_nack", 32'(nack), 0);
    @(negedge clk);
    check_bytes();
    repeat (4) @(negedge clk);
    // back-to-back: req held high through done
    cur = vecs[2];
    exp_q.push_back({7'h3C, 1'b1});
    @(negedge clk);
    req = 1'b1;
    rw = 1'b1;
    addr = 7'h3C;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_accept1", 32'(busy), 1);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done1", 32'(done), 1);
    chk("b2b_rdata1", 32'(rdata), 8'h96);
    chk("b2b_nack1", 32'(nack), 0);
    check_bytes();
    cur = vecs[0];
    rw = 1'b0;
    addr = 7'h50;
    wdata = 8'hA5;
    exp_q.push_back({7'h50, 1'b0});
    exp_q.push_back(8'hA5);
    @(negedge clk);
    chk("b2b_accept2", 32'(busy), 1);
    chk("b2b_done_low", 32'(done), 0);
    chk("b2b_rdata_held", 32'(rdata), 8'h96);
    req = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done2", 32'(done), 1);
    chk("b2b_latency2", 32'(n), 160);
    chk("b2b_rdata2", 32'(rdata), 8'h96);
    chk("b2b_nack2", 32'(nack), 0);
    @(negedge clk);
    check_bytes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
